// File: rtl/pipe_stage_regs.sv
// Pipeline register bank for the 5-stage RV32I core: PC, F/D, D/E, E/M and M/W.
// Bubbles inserted by flush or by an invalid D slot are hazard-neutral: rd=0,
// regWrite=0 and resultSrc=00, so they never forward or cause load-use stalls.
// Optional feature macro: PIPE_PERF_CNT_EN enables saturating performance counters
// (retired instructions, fetch-stall cycles, D-flush cycles). Without it, the Po_*
// ports are tied to zero and no counter flops exist.
module pipe_stage_regs #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic            clk,
  input  logic            reset_x,

  // Fetch
  input  logic [XLEN-1:0] Fi_pcNext,
  input  logic [31:0]     Fi_instr,
  output logic [XLEN-1:0] Fo_pc,

  // Hazard unit controls
  input  logic            Fo_stall,
  input  logic            Do_stall,
  input  logic            Do_flush,
  input  logic            Eo_flush,

  // Decode
  output logic [31:0]     Do_instr,
  output logic [XLEN-1:0] Do_pc,
  output logic            Do_valid,
  input  logic [4:0]      Di_rs1,
  input  logic [4:0]      Di_rs2,
  input  logic [4:0]      Di_rd,
  input  logic            Di_regWrite,
  input  logic [1:0]      Di_resultSrc,

  // Execute
  output logic [4:0]      Eo_rs1,
  output logic [4:0]      Eo_rs2,
  output logic [4:0]      Eo_rd,
  output logic            Eo_regWrite,
  output logic [1:0]      Eo_resultSrc,
  output logic [XLEN-1:0] Eo_pc,
  output logic            Eo_valid,

  // Memory
  output logic [4:0]      Mo_rd,
  output logic            Mo_regWrite,
  output logic [1:0]      Mo_resultSrc,
  output logic            Mo_valid,

  // Writeback
  output logic [4:0]      Wo_rd,
  output logic            Wo_regWrite,
  output logic [1:0]      Wo_resultSrc,
  output logic            Wo_valid,

  // Performance counters
  output logic [CNT_W-1:0] Po_retired,
  output logic [CNT_W-1:0] Po_stallCyc,
  output logic [CNT_W-1:0] Po_flushCnt
);

  // addi x0, x0, 0
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] r_f_pc;

  logic [31:0]     r_d_instr;
  logic [XLEN-1:0] r_d_pc;
  logic            r_d_valid;

  logic [4:0]      r_e_rs1;
  logic [4:0]      r_e_rs2;
  logic [4:0]      r_e_rd;
  logic            r_e_reg_write;
  logic [1:0]      r_e_result_src;
  logic [XLEN-1:0] r_e_pc;
  logic            r_e_valid;

  logic [4:0]      r_m_rd;
  logic            r_m_reg_write;
  logic [1:0]      r_m_result_src;
  logic            r_m_valid;

  logic [4:0]      r_w_rd;
  logic            r_w_reg_write;
  logic [1:0]      r_w_result_src;
  logic            r_w_valid;

  // Next-state values for PC, F/D and D/E
  logic [XLEN-1:0] w_f_pc_d;

  logic [31:0]     w_d_instr_d;
  logic [XLEN-1:0] w_d_pc_d;
  logic            w_d_valid_d;

  logic [4:0]      w_e_rs1_d;
  logic [4:0]      w_e_rs2_d;
  logic [4:0]      w_e_rd_d;
  logic            w_e_reg_write_d;
  logic [1:0]      w_e_result_src_d;
  logic [XLEN-1:0] w_e_pc_d;
  logic            w_e_valid_d;

  // ---------------------------------------------------------------------------
  // PC and F/D
  // ---------------------------------------------------------------------------

  // PC advances unless the fetch stage is stalled.
  always_comb begin
    w_f_pc_d = r_f_pc;
    if (!Fo_stall) begin
      w_f_pc_d = Fi_pcNext;
    end
  end

  // F/D next state: flush beats stall beats load.
  always_comb begin
    w_d_instr_d = r_d_instr;
    w_d_pc_d    = r_d_pc;
    w_d_valid_d = r_d_valid;
    if (Do_flush) begin
      w_d_instr_d = NopInstr;
      w_d_pc_d    = '0;
      w_d_valid_d = 1'b0;
    end else if (!Do_stall) begin
      w_d_instr_d = Fi_instr;
      w_d_pc_d    = r_f_pc;
      w_d_valid_d = 1'b1;
    end
  end

  // PC and F/D state registers.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      r_f_pc    <= RESET_PC;
      r_d_instr <= NopInstr;
      r_d_pc    <= '0;
      r_d_valid <= 1'b0;
    end else begin
      r_f_pc    <= w_f_pc_d;
      r_d_instr <= w_d_instr_d;
      r_d_pc    <= w_d_pc_d;
      r_d_valid <= w_d_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // D/E
  // ---------------------------------------------------------------------------

  // D/E next state: flush inserts a neutral bubble; an invalid D slot loads with
  // rd/regWrite masked so the NOP's decode cannot look like a register writer.
  always_comb begin
    w_e_rs1_d        = Di_rs1;
    w_e_rs2_d        = Di_rs2;
    w_e_rd_d         = r_d_valid ? Di_rd : 5'd0;
    w_e_reg_write_d  = r_d_valid & Di_regWrite;
    w_e_result_src_d = Di_resultSrc;
    w_e_pc_d         = r_d_pc;
    w_e_valid_d      = r_d_valid;
    if (Eo_flush) begin
      w_e_rs1_d        = 5'd0;
      w_e_rs2_d        = 5'd0;
      w_e_rd_d         = 5'd0;
      w_e_reg_write_d  = 1'b0;
      w_e_result_src_d = 2'b00;
      w_e_pc_d         = '0;
      w_e_valid_d      = 1'b0;
    end
  end

  // D/E state register; E has no stall, a load-use stall bubbles E instead.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      r_e_rs1        <= 5'd0;
      r_e_rs2        <= 5'd0;
      r_e_rd         <= 5'd0;
      r_e_reg_write  <= 1'b0;
      r_e_result_src <= 2'b00;
      r_e_pc         <= '0;
      r_e_valid      <= 1'b0;
    end else begin
      r_e_rs1        <= w_e_rs1_d;
      r_e_rs2        <= w_e_rs2_d;
      r_e_rd         <= w_e_rd_d;
      r_e_reg_write  <= w_e_reg_write_d;
      r_e_result_src <= w_e_result_src_d;
      r_e_pc         <= w_e_pc_d;
      r_e_valid      <= w_e_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // E/M and M/W
  // ---------------------------------------------------------------------------

  // E/M and M/W advance every cycle; a branch resolving in E still reaches M.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      r_m_rd         <= 5'd0;
      r_m_reg_write  <= 1'b0;
      r_m_result_src <= 2'b00;
      r_m_valid      <= 1'b0;
      r_w_rd         <= 5'd0;
      r_w_reg_write  <= 1'b0;
      r_w_result_src <= 2'b00;
      r_w_valid      <= 1'b0;
    end else begin
      r_m_rd         <= r_e_rd;
      r_m_reg_write  <= r_e_reg_write;
      r_m_result_src <= r_e_result_src;
      r_m_valid      <= r_e_valid;
      r_w_rd         <= r_m_rd;
      r_w_reg_write  <= r_m_reg_write;
      r_w_result_src <= r_m_result_src;
      r_w_valid      <= r_m_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_retired;
  logic [CNT_W-1:0] r_stall_cyc;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating event counters; they stick at all-ones rather than wrap.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      r_retired   <= '0;
      r_stall_cyc <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (r_w_valid && (r_retired != '1)) begin
        r_retired <= r_retired + CNT_W'(1);
      end
      if (Fo_stall && (r_stall_cyc != '1)) begin
        r_stall_cyc <= r_stall_cyc + CNT_W'(1);
      end
      if (Do_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign Po_retired  = r_retired;
  assign Po_stallCyc = r_stall_cyc;
  assign Po_flushCnt = r_flush_cnt;
`else
  assign Po_retired  = '0;
  assign Po_stallCyc = '0;
  assign Po_flushCnt = '0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs (all straight from flops)
  // ---------------------------------------------------------------------------
  assign Fo_pc        = r_f_pc;

  assign Do_instr     = r_d_instr;
  assign Do_pc        = r_d_pc;
  assign Do_valid     = r_d_valid;

  assign Eo_rs1       = r_e_rs1;
  assign Eo_rs2       = r_e_rs2;
  assign Eo_rd        = r_e_rd;
  assign Eo_regWrite  = r_e_reg_write;
  assign Eo_resultSrc = r_e_result_src;
  assign Eo_pc        = r_e_pc;
  assign Eo_valid     = r_e_valid;

  assign Mo_rd        = r_m_rd;
  assign Mo_regWrite  = r_m_reg_write;
  assign Mo_resultSrc = r_m_result_src;
  assign Mo_valid     = r_m_valid;

  assign Wo_rd        = r_w_rd;
  assign Wo_regWrite  = r_w_reg_write;
  assign Wo_resultSrc = r_w_result_src;
  assign Wo_valid     = r_w_valid;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Testbench for pipe_stage_regs: directed hazard scenarios with a retirement
// scoreboard checked at writeback, plus direct register checks per scenario.
module tb_pipe_stage_regs;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  logic            clk = 1'b0;
  logic            reset_x = 1'b0;
  logic [XLEN-1:0] Fi_pcNext;
  logic [31:0]     Fi_instr;
  logic [XLEN-1:0] Fo_pc;
  logic            Fo_stall = 1'b0;
  logic            Do_stall = 1'b0;
  logic            Do_flush = 1'b0;
  logic            Eo_flush = 1'b0;
  logic [31:0]     Do_instr;
  logic [XLEN-1:0] Do_pc;
  logic            Do_valid;
  logic [4:0]      Di_rs1, Di_rs2, Di_rd;
  logic            Di_regWrite;
  logic [1:0]      Di_resultSrc;
  logic [4:0]      Eo_rs1, Eo_rs2, Eo_rd;
  logic            Eo_regWrite;
  logic [1:0]      Eo_resultSrc;
  logic [XLEN-1:0] Eo_pc;
  logic            Eo_valid;
  logic [4:0]      Mo_rd;
  logic            Mo_regWrite;
  logic [1:0]      Mo_resultSrc;
  logic            Mo_valid;
  logic [4:0]      Wo_rd;
  logic            Wo_regWrite;
  logic [1:0]      Wo_resultSrc;
  logic            Wo_valid;
  logic [CNT_W-1:0] Po_retired, Po_stallCyc, Po_flushCnt;

  logic        redir = 1'b0;
  logic [31:0] target = 32'h200;

  always #5 clk = ~clk;

  // Destination register encoded into each instruction word from its address.
  function automatic logic [4:0] pc_rd(input logic [31:0] pc);
    logic [4:0] f;
    f = pc[6:2];
    return f + 5'd1;
  endfunction

  // Instruction memory: ADDI / store / load depending on pc[3:2].
  function automatic logic [31:0] imem(input logic [31:0] pc);
    logic [1:0] k;
    k = pc[3:2];
    case (k)
      2'b10:   return {7'h00, 5'd2, 5'd1, 3'b010, pc_rd(pc), 7'h23};
      2'b11:   return {12'h000, 5'd1, 3'b010, pc_rd(pc), 7'h03};
      default: return {12'h004, 5'd1, 3'b000, pc_rd(pc), 7'h13};
    endcase
  endfunction

  assign Fi_pcNext    = redir ? target : Fo_pc + 32'd4;
  assign Fi_instr     = imem(Fo_pc);
  assign Di_rd        = Do_instr[11:7];
  assign Di_rs1       = Do_instr[19:15];
  assign Di_rs2       = Do_instr[24:20];
  assign Di_regWrite  = (Do_instr[6:0] != 7'h23);
  assign Di_resultSrc = (Do_instr[6:0] == 7'h03) ? 2'b01 : 2'b00;

  pipe_stage_regs #(
    .XLEN     (XLEN),
    .RESET_PC (32'h0000_0100),
    .CNT_W    (CNT_W)
  ) u_dut (
    .clk          (clk),
    .reset_x      (reset_x),
    .Fi_pcNext    (Fi_pcNext),
    .Fi_instr     (Fi_instr),
    .Fo_pc        (Fo_pc),
    .Fo_stall     (Fo_stall),
    .Do_stall     (Do_stall),
    .Do_flush     (Do_flush),
    .Eo_flush     (Eo_flush),
    .Do_instr     (Do_instr),
    .Do_pc        (Do_pc),
    .Do_valid     (Do_valid),
    .Di_rs1       (Di_rs1),
    .Di_rs2       (Di_rs2),
    .Di_rd        (Di_rd),
    .Di_regWrite  (Di_regWrite),
    .Di_resultSrc (Di_resultSrc),
    .Eo_rs1       (Eo_rs1),
    .Eo_rs2       (Eo_rs2),
    .Eo_rd        (Eo_rd),
    .Eo_regWrite  (Eo_regWrite),
    .Eo_resultSrc (Eo_resultSrc),
    .Eo_pc        (Eo_pc),
    .Eo_valid     (Eo_valid),
    .Mo_rd        (Mo_rd),
    .Mo_regWrite  (Mo_regWrite),
    .Mo_resultSrc (Mo_resultSrc),
    .Mo_valid     (Mo_valid),
    .Wo_rd        (Wo_rd),
    .Wo_regWrite  (Wo_regWrite),
    .Wo_resultSrc (Wo_resultSrc),
    .Wo_valid     (Wo_valid),
    .Po_retired   (Po_retired),
    .Po_stallCyc  (Po_stallCyc),
    .Po_flushCnt  (Po_flushCnt)
  );

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] ExpRetired = 4'hF;
  localparam logic [CNT_W-1:0] ExpStall   = 4'd2;
  localparam logic [CNT_W-1:0] ExpFlush   = 4'd11;
`else
  localparam logic [CNT_W-1:0] ExpRetired = 4'd0;
  localparam logic [CNT_W-1:0] ExpStall   = 4'd0;
  localparam logic [CNT_W-1:0] ExpFlush   = 4'd0;
`endif

  typedef struct packed {
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] edge_n;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned edge_cnt = 0;
  int unsigned base = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Queue an expected retirement: instruction at pc reaching W after edge base+rel.
  task automatic push_exp(input logic [31:0] pc, input int rel);
    exp_t e;
    logic [1:0] k;
    k        = pc[3:2];
    e.rd     = pc_rd(pc);
    e.rw     = (k != 2'b10);
    e.rs     = (k == 2'b11) ? 2'b01 : 2'b00;
    e.edge_n = base + rel;
    sb_q.push_back(e);
  endtask

  // Drive one cycle of hazard controls, return at the following falling edge.
  task automatic step(input logic fs, input logic ds, input logic df, input logic ef,
                      input logic rdr);
    Fo_stall = fs;
    Do_stall = ds;
    Do_flush = df;
    Eo_flush = ef;
    redir    = rdr;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    // Writeback monitor, decoupled from stimulus.
    fork
      forever begin
        @(negedge clk);
        if (Wo_valid) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wb_unexpected: got rd=%0d at edge %0d, expected no retirement",
                     Wo_rd, edge_cnt);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("wb_retire{rd,rw,rs,edge}",
                {24'd0, Wo_rd, Wo_regWrite, Wo_resultSrc, edge_cnt},
                {24'd0, e.rd, e.rw, e.rs, e.edge_n});
          end
        end
      end
    join_none

    // Reset held for three edges.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pc",       Fo_pc,    32'h100);
    chk("rst_instr",    Do_instr, 32'h13);
    chk("rst_valids",   {Do_valid, Eo_valid, Mo_valid, Wo_valid}, 4'b0000);
    chk("rst_ctrl",     {Eo_rd, Eo_regWrite, Wo_rd, Wo_regWrite}, 12'h0);
    chk("rst_perf",     {Po_retired, Po_stallCyc, Po_flushCnt}, 12'h0);
    reset_x = 1'b1;
    base    = edge_cnt;

    // Expected retirements in order (relative edge numbers worked out by hand).
    for (int j = 0; j <= 3; j++) push_exp(32'h100 + 4 * j, j + 4);
    for (int j = 4; j <= 6; j++) push_exp(32'h100 + 4 * j, j + 5);   // after load-use stall
    for (int m = 0; m <= 4; m++) push_exp(32'h200 + 4 * m, m + 14);  // branch target
    for (int m = 6; m <= 8; m++) push_exp(32'h200 + 4 * m, m + 14);  // 0x214 flushed
    for (int m = 9; m <= 15; m++) push_exp(32'h200 + 4 * m, m + 15); // after PC hold

    for (int k = 1; k <= 35; k++) begin
      case (k)
        6:       step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0); // load-use
        10:      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1); // taken branch to 0x200
        16:      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); // flush with stall
        20:      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // PC hold with D flush
        default: step(1'b0, 1'b0, (k >= 28), 1'b0, 1'b0);
      endcase
      case (k)
        1: chk("k1_d", {Do_instr, Do_pc, 31'd0, Do_valid}, {imem(32'h100), 32'h100, 32'd1});
        5: chk("k5_e_load", {Eo_rd, Eo_resultSrc, Eo_pc}, {5'd4, 2'b01, 32'h10C});
        6: begin
          chk("k6_pc_hold", Fo_pc, 32'h114);
          chk("k6_d_hold",  {Do_pc, 31'd0, Do_valid}, {32'h110, 32'd1});
          chk("k6_e_bubble", {Eo_valid, Eo_rd, Eo_regWrite}, 7'd0);
        end
        7: chk("k7_e", {Eo_valid, Eo_rs1, Eo_rs2, Eo_resultSrc, Eo_pc},
               {1'b1, 5'd1, 5'd4, 2'b00, 32'h110});
        10: begin
          chk("k10_pc_redirect", Fo_pc, 32'h200);
          chk("k10_bubbles", {Do_valid, Eo_valid, Do_instr}, {2'b00, 32'h13});
          chk("k10_branch_m", {Mo_valid, Mo_rd}, {1'b1, 5'd7});
        end
        11: chk("k11_mask", {Eo_valid, Eo_rd, Eo_regWrite, Eo_pc}, 39'd0);
        16: begin
          chk("k16_flush_wins", {Do_instr, Do_pc, 31'd0, Do_valid}, {32'h13, 32'h0, 32'd0});
          chk("k16_pc_e", {Fo_pc, Eo_pc}, {32'h218, 32'h210});
        end
        20: begin
          chk("k20_pc_hold", Fo_pc, 32'h224);
          chk("k20_d_e", {Do_valid, Eo_valid, Eo_pc}, {2'b01, 32'h220});
        end
        35: begin
          chk("perf_retired", Po_retired,  ExpRetired);
          chk("perf_stall",   Po_stallCyc, ExpStall);
          chk("perf_flush",   Po_flushCnt, ExpFlush);
        end
        default: ;
      endcase
    end

    // Refill, then reset mid-flight: must act without a clock edge.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 reset_x = 1'b0;
    #1;
    chk("arst_pc_instr", {Fo_pc, Do_instr}, {32'h100, 32'h13});
    chk("arst_valids",   {Do_valid, Eo_valid, Mo_valid, Wo_valid}, 4'b0000);
    chk("arst_perf",     {Po_retired, Po_stallCyc, Po_flushCnt}, 12'h0);
    @(negedge clk);
    reset_x = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_d", {Do_pc, 31'd0, Do_valid, Fo_pc}, {32'h100, 32'd1, 32'h104});
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
